// File: rtl/axi_fb_writer.sv
// AXI4 write-channel master: buffers an input beat stream and writes it out as INCR bursts.
// Optional feature macro: AXI_FB_WRITER_BRESP_CHECK_EN (error responses set err_o and abort the frame).
module axi_fb_writer #(
    parameter int          AXI_ADDR_W = 64,
    parameter int          AXI_DATA_W = 64,
    parameter int          AXI_ID_W   = 4,
    parameter int unsigned AXI_ID     = 0,
    parameter int          BURST_LEN  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AXI_ADDR_W-1:0]   cfg_baseaddr,
    input  logic [31:0]             cfg_beats,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AXI_DATA_W-1:0]   s_data,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [AXI_ID_W-1:0]     m_axi_awid,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [AXI_DATA_W-1:0]   m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [AXI_ID_W-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int BYTES = AXI_DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int DEPTH = 2 * BURST_LEN;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    if (!(AXI_DATA_W == 32 || AXI_DATA_W == 64)) begin : g_bad_dw
        $error("axi_fb_writer: AXI_DATA_W must be 32 or 64");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256 || (BURST_LEN & (BURST_LEN - 1)) != 0 ||
        BURST_LEN * BYTES > 4096) begin : g_bad_bl
        $error("axi_fb_writer: illegal BURST_LEN");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t                  state, state_nxt;
    logic [AXI_ADDR_W-1:0]   addr;
    logic [31:0]             remain;
    logic [31:0]             beats;
    logic [31:0]             accepted;
    logic [8:0]              blen;
    logic [7:0]              wcnt;

    logic [AXI_DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           cnt;
    logic                    full, push, pop;
    logic                    aw_hs, b_hs, b_err, frame_end;
    logic                    unused_bits;

    assign blen = (remain < 32'(BURST_LEN)) ? remain[8:0] : 9'(BURST_LEN);

    // FIFO side: wvalid/wdata/wlast and s_ready come straight from FIFO state.
    assign full          = (cnt == CW'(DEPTH));
    assign s_ready       = busy_o && !full && (accepted < beats);
    assign push          = s_valid && s_ready;
    assign m_axi_wvalid  = (state == ST_W) && (cnt != '0);
    assign m_axi_wdata   = mem[rd_ptr];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = m_axi_wvalid && ({1'b0, wcnt} == blen - 9'd1);
    assign pop           = m_axi_wvalid && m_axi_wready;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;

`ifdef AXI_FB_WRITER_BRESP_CHECK_EN
    assign b_err = (m_axi_bresp != 2'b00);
`else
    assign b_err = 1'b0;
`endif

    assign frame_end   = b_hs && (b_err || (remain == 32'(blen)));
    assign unused_bits = ^{m_axi_bid, m_axi_bresp};

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i && cfg_beats != 32'd0) state_nxt = ST_AW;
            ST_AW:   if (aw_hs) state_nxt = ST_W;
            ST_W:    if (pop && m_axi_wlast) state_nxt = ST_B;
            ST_B:    if (b_hs) state_nxt = frame_end ? ST_IDLE : ST_AW;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr          <= '0;
            remain        <= '0;
            beats         <= '0;
            accepted      <= '0;
            wcnt          <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awsize  <= '0;
            m_axi_awburst <= '0;
            m_axi_awid    <= '0;
            m_axi_bready  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (cfg_beats != 32'd0) begin
                            addr     <= cfg_baseaddr;
                            remain   <= cfg_beats;
                            beats    <= cfg_beats;
                            accepted <= '0;
                            busy_o   <= 1'b1;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_AW: begin
                    // Only request the burst once all of its beats are buffered so W never stalls.
                    if (m_axi_awvalid) begin
                        if (m_axi_awready) begin
                            m_axi_awvalid <= 1'b0;
                            wcnt          <= '0;
                        end
                    end else if (32'(cnt) >= 32'(blen)) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= addr;
                        m_axi_awlen   <= 8'(blen - 9'd1);
                        m_axi_awsize  <= 3'(SIZE);
                        m_axi_awburst <= 2'b01;
                        m_axi_awid    <= AXI_ID_W'(AXI_ID);
                    end
                end
                ST_W: begin
                    if (pop) begin
                        wcnt <= wcnt + 8'd1;
                        if (m_axi_wlast) m_axi_bready <= 1'b1;
                    end
                end
                ST_B: begin
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        addr         <= addr + (AXI_ADDR_W'(blen) << SIZE);
                        remain       <= remain - 32'(blen);
                        if (frame_end) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (push) accepted <= accepted + 32'd1;
        end
    end

    // An aborted frame discards whatever is still buffered.
    always_ff @(posedge clk_i) begin
        if (rst_i || (b_hs && b_err)) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= s_data;
    end

`ifdef AXI_FB_WRITER_BRESP_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                            err_o <= 1'b0;
        else if (state == ST_IDLE && start_i) err_o <= 1'b0;
        else if (b_hs && b_err)               err_o <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_fb_writer.sv
// Self-checking bench for axi_fb_writer: burst-level model, data scoreboard and directed frames.
module tb_axi_fb_writer;
    localparam int BL    = 16;
    localparam int BYTES = 8;
    localparam int DEPTH = 2 * BL;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [63:0] base = '0;
    logic [31:0] beats = '0;
    logic        s_valid = 1'b0, s_ready;
    logic [63:0] s_data = '0;
    logic        awvalid, awready = 1'b0;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        wvalid, wready = 1'b0, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [3:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        busy, done, err;

    always #5 clk = ~clk;

    axi_fb_writer #(.AXI_ADDR_W(64), .AXI_DATA_W(64), .AXI_ID_W(4), .AXI_ID(0), .BURST_LEN(BL)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_baseaddr(base), .cfg_beats(beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awid(awid),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid),
        .m_axi_bresp(bresp), .busy_o(busy), .done_o(done), .err_o(err)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave and producer knobs
    int aw_delay = 0, aw_wait = 0, sl_bcnt = 0;
    bit wtog = 1'b0, err_first = 1'b0;
    int prod_idx = 0, offer_n = 0, frame_id = 0;

    // Model state
    bit          busy_m = 0, done_m = 0, awv_m = 0, aw_ph = 0, w_ph = 0, b_ph = 0;
    int          pushed = 0, popped = 0, beats_m = 0, b_cnt = 0, cur_len = 0, beat_i = 0;
    int          n_bursts_exp = 0, frame_w = 0, aw_cnt = 0;
    logic [63:0] exp_addr_q[$], data_q[$], log_addr[$];
    int          exp_len_q[$], log_len[$], wlast_pos[$];

    initial begin : slave
        bit s_aw, s_awwait, s_wl, s_b;
        forever begin
            @(negedge clk);
            s_aw     = awvalid && awready;
            s_awwait = awvalid && !awready;
            s_wl     = wvalid && wready && wlast;
            s_b      = bvalid && bready;
            @(posedge clk);
            #1;
            if (aw_delay == 0) awready = 1'b1;
            else if (s_aw) begin awready = 1'b0; aw_wait = 0; end
            else if (s_awwait) begin aw_wait++; awready = (aw_wait >= aw_delay); end
            else begin awready = 1'b0; aw_wait = 0; end
            wready = wtog ? ~wready : 1'b1;
            if (rst || s_b) bvalid = 1'b0;
            else if (s_wl) begin
                bvalid = 1'b1;
                bresp  = (err_first && sl_bcnt == 0) ? 2'b10 : 2'b00;
                sl_bcnt++;
            end
        end
    end

    initial begin : producer
        bit hs;
        forever begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) prod_idx++;
            s_valid = (prod_idx < offer_n);
            s_data  = {32'(frame_id), 32'(prod_idx)} ^ 64'hA5A5_0000_0000_5A5A;
        end
    end

    initial begin : compare
        int fifo;
        bit e_srdy, e_wv, e_wl, aw_hs, w_hs, b_hs, s_hs, done_n, awv_n, pa, pw, pb;
        forever begin
            @(negedge clk);
            fifo   = pushed - popped;
            e_srdy = busy_m && (fifo < DEPTH) && (pushed < beats_m);
            e_wv   = w_ph && (fifo > 0);
            e_wl   = e_wv && (beat_i == cur_len);
            chk("busy", busy, busy_m);
            chk("done", done, done_m);
            chk("s_ready", s_ready, e_srdy);
            chk("awvalid", awvalid, awv_m);
            chk("wvalid", wvalid, e_wv);
            chk("wlast", wlast, e_wl);
            chk("bready", bready, b_ph);
            if (awvalid && awv_m) begin
                if (exp_len_q.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    chk("awaddr", awaddr, exp_addr_q[0]);
                    chk("awlen", awlen, 64'(exp_len_q[0]));
                    chk("awsize", awsize, 3);
                    chk("awburst", awburst, 1);
                    chk("awid", awid, 0);
                end
            end
            if (wvalid && wready) chk("wstrb", wstrb, 64'hFF);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            s_hs  = s_valid && s_ready;
            if (s_hs) data_q.push_back(s_data);
            if (w_hs) begin
                if (data_q.size() == 0) chk("wdata_underflow", 1, 0);
                else chk("wdata", wdata, data_q.pop_front());
                frame_w++;
                if (wlast) wlast_pos.push_back(frame_w);
            end
            done_n = 1'b0;
            awv_n  = awv_m;
            pa = aw_ph; pw = w_ph; pb = b_ph;
            if (rst) begin
                busy_m = 0; aw_ph = 0; w_ph = 0; b_ph = 0; awv_n = 0;
                pushed = 0; popped = 0; beats_m = 0;
                exp_addr_q.delete(); exp_len_q.delete(); data_q.delete();
            end else begin
                if (pa && aw_hs) begin
                    awv_n = 0; aw_ph = 0; w_ph = 1; beat_i = 0; aw_cnt++;
                    log_addr.push_back(awaddr);
                    log_len.push_back(int'(awlen));
                    if (exp_len_q.size() > 0) begin
                        cur_len = exp_len_q.pop_front();
                        void'(exp_addr_q.pop_front());
                    end
                end else if (pa && !awv_m && exp_len_q.size() > 0 && fifo >= exp_len_q[0] + 1)
                    awv_n = 1;
                if (pw && w_hs) begin
                    beat_i++;
                    if (wlast) begin w_ph = 0; b_ph = 1; end
                end
                if (pb && b_hs) begin
                    b_ph = 0; b_cnt++;
                    if (b_cnt >= n_bursts_exp) begin busy_m = 0; done_n = 1; end
                    else aw_ph = 1;
                end
                pushed += int'(s_hs);
                popped += int'(w_hs);
                if (!busy_m && !pb && start) begin
                    if (beats != 0) begin
                        busy_m = 1; aw_ph = 1; pushed = 0; popped = 0; beats_m = int'(beats); b_cnt = 0;
                        frame_w = 0; aw_cnt = 0;
                        data_q.delete(); log_addr.delete(); log_len.delete(); wlast_pos.delete();
                    end else done_n = 1;
                end
            end
            done_m = done_n;
            awv_m  = awv_n;
        end
    end

    task automatic run_frame(input logic [63:0] b, input int n, input int offer, input int awd,
                             input bit tog, input bit eb, input int rst_at);
        int rem, nb, len;
        bit abort, got;
`ifdef AXI_FB_WRITER_BRESP_CHECK_EN
        abort = eb;
`else
        abort = 1'b0;
`endif
        @(posedge clk);
        #2;
        aw_delay = awd; wtog = tog; err_first = eb; sl_bcnt = 0;
        exp_addr_q.delete(); exp_len_q.delete();
        rem = n; nb = 0;
        while (rem > 0) begin
            len = (rem < BL) ? rem : BL;
            exp_addr_q.push_back(b + 64'(nb * BL * BYTES));
            exp_len_q.push_back(len - 1);
            rem -= len; nb++;
            if (abort) break;
        end
        n_bursts_exp = nb;
        frame_id++; prod_idx = 0; offer_n = offer;
        start = 1'b1; base = b; beats = 32'(n);
        @(posedge clk);
        #1 chk("busy_after_start", busy, 1);
        chk("err_cleared_by_start", err, 0);
        #1 start = 1'b0;
        got = 1'b0;
        if (rst_at > 0) begin
            for (int i = 0; i < 4000 && !got; i++) begin
                @(negedge clk);
                if (frame_w >= rst_at) got = 1'b1;
            end
            chk("reached_w_phase", got, 1);
            @(posedge clk);
            #2 rst = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_wvalid", wvalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_awvalid", awvalid, 0);
            chk("rst_s_ready", s_ready, 0);
            #1 rst = 1'b0; offer_n = 0;
        end else begin
            for (int i = 0; i < 4000 && !got; i++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            chk("done_seen", got, 1);
            repeat (2) @(negedge clk);
            chk("aw_count", aw_cnt, nb);
            chk("err_end", err, abort);
            chk("s_ready_end", s_ready, 0);
            if (!abort) begin
                chk("w_total", frame_w, n);
                chk("data_left", data_q.size(), 0);
            end
            @(posedge clk);
            #2 offer_n = 0;
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit eabort;
`ifdef AXI_FB_WRITER_BRESP_CHECK_EN
        eabort = 1'b1;
`else
        eabort = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk("rst_awvalid0", awvalid, 0);
        chk("rst_wvalid0", wvalid, 0);
        chk("rst_bready0", bready, 0);
        chk("rst_s_ready0", s_ready, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_err0", err, 0);
        chk("rst_wlast0", wlast, 0);
        chk("rst_awaddr0", awaddr, 0);
        chk("rst_awlen0", awlen, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Zero-length frame: done next cycle, never busy.
        @(posedge clk);
        #2 start = 1'b1; beats = 0; base = 64'h1000;
        @(posedge clk);
        #1 chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        #1 start = 1'b0;
        @(posedge clk);
        #1 chk("zero_done_clear", done, 0);

        // 32 beats: two full bursts.
        run_frame(64'h1000, 32, 32, 0, 0, 0, 0);
        chk("t1_nbursts", log_addr.size(), 2);
        if (log_addr.size() >= 2) begin
            chk("t1_addr0", log_addr[0], 64'h1000);
            chk("t1_addr1", log_addr[1], 64'h1080);
            chk("t1_len0", log_len[0], 15);
            chk("t1_len1", log_len[1], 15);
        end

        // 20 beats: a full burst then a 4-beat tail.
        run_frame(64'h1000, 20, 20, 0, 0, 0, 0);
        chk("t2_nbursts", log_addr.size(), 2);
        chk("t2_nlast", wlast_pos.size(), 2);
        if (log_addr.size() >= 2 && wlast_pos.size() >= 2) begin
            chk("t2_len0", log_len[0], 15);
            chk("t2_addr1", log_addr[1], 64'h1080);
            chk("t2_len1", log_len[1], 3);
            chk("t2_last0", wlast_pos[0], 16);
            chk("t2_last1", wlast_pos[1], 20);
        end
        chk("t2_wtotal", frame_w, 20);

        // awready stalled 5 cycles, wready toggling.
        run_frame(64'h3000, 32, 32, 5, 1, 0, 0);
        chk("t3_wtotal", frame_w, 32);

        // Producer over-offers: only the frame length is accepted.
        run_frame(64'h4000, 32, 40, 0, 0, 0, 0);
        chk("t4_accepted", prod_idx, 32);

        // Error response on the first burst.
        run_frame(64'h1000, 32, 32, 0, 0, 1, 0);
        chk("t5_bursts", aw_cnt, eabort ? 1 : 2);

        // Reset during the first burst, then a clean frame at 0x2000.
        run_frame(64'h1000, 32, 32, 0, 0, 0, 3);
        run_frame(64'h2000, 32, 32, 0, 0, 0, 0);
        chk("t6_nbursts", log_addr.size(), 2);
        if (log_addr.size() >= 2) begin
            chk("t6_addr0", log_addr[0], 64'h2000);
            chk("t6_addr1", log_addr[1], 64'h2080);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_fb_writer.md
# axi_fb_writer

AXI4 write-channel master that streams a frame of pixel/character data into framebuffer memory as INCR bursts. It is the write-side counterpart of the VGA card's read master: a CPU-side or DMA-side producer pushes beats in over a valid/ready stream, and the block issues AW/W/B transactions toward an `axi2mem`-style slave. Read channels are not used.

## Interface
- `AXI_ADDR_W`, default 64: AXI address width.
- `AXI_DATA_W`, default 64: data width; only 32 or 64 are legal.
- `AXI_ID_W`, default 4: ID width.
- `AXI_ID`, default 0: constant `awid` value.
- `BURST_LEN`, default 16: maximum beats per burst, power of two, 1..256. `BURST_LEN*AXI_DATA_W/8` must be ≤ 4096.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous reset, active-high.
- `start_i` in 1: one-cycle frame start pulse. Sampled only in IDLE.
- `cfg_baseaddr` in AXI_ADDR_W: frame base. Must be aligned to `BURST_LEN*AXI_DATA_W/8`. Latched on start.
- `cfg_beats` in 32: frame length in beats. Latched on start; 0 means no-op.
- `s_valid` in 1, `s_ready` out 1, `s_data` in AXI_DATA_W: input data stream.
- `m_axi_awvalid` out 1, `m_axi_awready` in 1, `m_axi_awaddr` out AXI_ADDR_W, `m_axi_awlen` out 8, `m_axi_awsize` out 3, `m_axi_awburst` out 2, `m_axi_awid` out AXI_ID_W: write address channel.
- `m_axi_wvalid` out 1, `m_axi_wready` in 1, `m_axi_wdata` out AXI_DATA_W, `m_axi_wstrb` out AXI_DATA_W/8, `m_axi_wlast` out 1: write data channel.
- `m_axi_bvalid` in 1, `m_axi_bready` out 1, `m_axi_bid` in AXI_ID_W, `m_axi_bresp` in 2: write response channel.
- `busy_o` out 1: a frame is in progress.
- `done_o` out 1: one-cycle pulse when the frame completes.
- `err_o` out 1: sticky error flag.

## Operation
- States are IDLE, AW, W, B.
- IDLE:
  - A `start_i` with `cfg_beats`≠0 latches `addr`←base and `remain`←`cfg_beats`, sets `accepted`←0, sets `busy_o`, and moves to AW.
  - A `start_i` with `cfg_beats`=0 pulses `done_o` the next cycle and stays in IDLE.
- Burst length: `blen = min(BURST_LEN, remain)`.
- AW:
  - Assert `awvalid` only once the FIFO holds ≥ `blen` beats, so W never starves.
  - Field values: `awaddr=addr`, `awlen=blen-1`, `awsize=log2(AXI_DATA_W/8)`, `awburst=2'b01`, `awid=AXI_ID`.
  - Hold the fields stable until `awready`, then go to W.
- W:
  - `wvalid` = FIFO not empty; `wdata` = FIFO head; `wstrb` all ones.
  - `wlast` on beat `blen-1`.
  - Pop on `wvalid&wready`. After `wlast` is accepted, go to B.
- B:
  - `bready=1`. On `bvalid`: `addr += blen*AXI_DATA_W/8`, `remain -= blen`.
  - If `remain` becomes 0, pulse `done_o`, clear `busy_o`, and go to IDLE; otherwise go to AW.
  - Exactly one burst is outstanding at a time.
- Input FIFO:
  - Depth `2*BURST_LEN`.
  - `s_ready = busy_o & !full & (accepted < beats)`. Beats beyond the frame length are never accepted.
  - Push and pop in the same cycle are legal; the count is unchanged.
- Bursts never cross 4 KB because the base is aligned and each burst size ≤ 4 KB.
- A `start_i` while busy is ignored.

## Timing
- Reset values: all valids 0, `bready` 0, `s_ready` 0, `busy_o` 0, `done_o` 0, `err_o` 0, `wlast` 0. Address and len outputs are 0. State is IDLE and the FIFO is empty.
- `start_i` → `busy_o` high the next cycle.
- First `awvalid` comes no earlier than the cycle after the FIFO count reaches `blen`.
- All outputs are registered except `s_ready` and `wvalid`/`wdata`/`wlast`, which come from FIFO state.
- `done_o` pulses the cycle after the final `bvalid&bready`. `busy_o` is low in that same cycle.
- `rst_i` mid-frame returns to IDLE, flushes the FIFO and drops all valids the next cycle. The slave must be reset concurrently.

## Configuration
- Macro: `AXI_FB_WRITER_BRESP_CHECK_EN`.
- Defined:
  - `bresp`≠OKAY sets `err_o`. It stays set until the next accepted `start_i` or reset.
  - The frame aborts: no further AW, the FIFO is flushed, the block returns to IDLE, and `done_o` still pulses.
- Undefined: `bresp` is ignored and `err_o` is tied to 0.

## Test plan
- Base 0x1000, 32 beats, BURST_LEN=16, slave always ready → AW at 0x1000 and 0x1080, both `awlen`=15, `awsize`=3. `done_o` pulses once after the 2nd B.
- 20 beats → first burst `awlen`=15 at 0x1000, then `awlen`=3 at 0x1080. `wlast` appears on beats 16 and 20. Total of 20 W handshakes.
- `awready` held low 5 cycles and `wready` toggling every cycle → `awaddr`/`awlen` stable while waiting, no beat lost or duplicated, data matches the input order.
- Producer offers 40 beats for a 32-beat frame → exactly 32 beats accepted, `s_ready`=0 afterwards.
- With the macro defined, `bresp`=2'b10 on the 1st B of a 32-beat frame → `err_o`=1, no 2nd AW, `done_o` pulse. Without the macro → 2 bursts and `err_o`=0.
- `rst_i` asserted during W of the 1st burst → next cycle `wvalid`=0, `busy_o`=0. A new start at 0x2000 runs cleanly.
